// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and sizes for the memory access controller and its row counter.
package mem_ctrl_pkg;

  localparam int ROWS   = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    CLEAR
  } state_e;

endpackage

// File: rtl/row_counter.sv
// Row index generator for the whole-array clear: synchronous clear/enable, wraps after the last row.
module row_counter
  import mem_ctrl_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign last = &count;

endmodule

// File: rtl/memory_access_controller.sv
// Valid/ready front end for the 8x8 memory array: single reads/writes, whole-array clear,
// registered array drive lines and a held read-response channel.
module memory_access_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ROWS  = mem_ctrl_pkg::ROWS,
  parameter int WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_cmd,
  input  logic [$clog2(ROWS)-1:0] req_addr,
  input  logic [WIDTH-1:0]        req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    clear_done,
  output logic                    cmd_err,
  output logic                    mem_op,
  output logic                    mem_select,
  output logic [$clog2(ROWS)-1:0] mem_address,
  output logic [WIDTH-1:0]        mem_data_input,
  input  logic [WIDTH-1:0]        mem_data_output
);

  localparam int AW = $clog2(ROWS);

  state_e          state_q, state_d;
  logic            req_ready_d, rsp_valid_d, clear_done_d, cmd_err_d;
  logic            mem_op_d, mem_select_d;
  logic [AW-1:0]   mem_address_d;
  logic [WIDTH-1:0] mem_data_input_d;
  logic            cnt_clr, cnt_en, cnt_last;
  logic [AW-1:0]   cnt;

  row_counter #(.W(AW)) u_row_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

  // Every output is registered, so this block computes the values for the *next* cycle;
  // the accepted request's address/data are latched straight into the array drive registers.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    req_ready_d      = 1'b0;
    rsp_valid_d      = 1'b0;
    clear_done_d     = 1'b0;
    cmd_err_d        = 1'b0;
    mem_op_d         = OP_READ;
    mem_select_d     = 1'b0;
    mem_address_d    = '0;
    mem_data_input_d = '0;
    cnt_clr          = 1'b0;
    cnt_en           = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        cnt_clr     = 1'b1;
        if (req_valid && req_ready) begin
          unique case (cmd_e'(req_cmd))
            CMD_READ: begin
              state_d       = READ;
              req_ready_d   = 1'b0;
              mem_select_d  = 1'b1;
              mem_address_d = req_addr;
            end
            CMD_WRITE: begin
              state_d          = WRITE;
              req_ready_d      = 1'b0;
              mem_select_d     = 1'b1;
              mem_op_d         = OP_WRITE;
              mem_address_d    = req_addr;
              mem_data_input_d = req_wdata;
            end
            CMD_CLEAR: begin
              state_d      = CLEAR;
              req_ready_d  = 1'b0;
              mem_select_d = 1'b1;
              mem_op_d     = OP_WRITE;
            end
            CMD_RSVD: cmd_err_d = 1'b1;
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      READ: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      CLEAR: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
          req_ready_d  = 1'b1;
        end else begin
          mem_select_d  = 1'b1;
          mem_op_d      = OP_WRITE;
          mem_address_d = cnt + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      clear_done     <= 1'b0;
      cmd_err        <= 1'b0;
      mem_op         <= OP_READ;
      mem_select     <= 1'b0;
      mem_address    <= '0;
      mem_data_input <= '0;
    end else begin
      state_q        <= state_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      clear_done     <= clear_done_d;
      cmd_err        <= cmd_err_d;
      mem_op         <= mem_op_d;
      mem_select     <= mem_select_d;
      mem_address    <= mem_address_d;
      mem_data_input <= mem_data_input_d;
      if (state_q == READ) begin
        rsp_rdata <= mem_data_output;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed plus randomized bench for memory_access_controller with a behavioural array and
// a transaction-level expected-contents model.
module tb_memory_access_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0] req_cmd;
  logic [2:0] req_addr, mem_address;
  logic [7:0] req_wdata, rsp_rdata, mem_data_input, mem_data_output;
  logic       clear_done, cmd_err, mem_op, mem_select;

  int passed = 0;
  int total  = 0;
  int sel_cycles = 0;
  int exp_sel    = 0;

  logic [7:0] arr     [8];
  logic [7:0] ref_mem [8];

  always #5 clk = ~clk;

  memory_access_controller #(.ROWS(8), .WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_cmd         (req_cmd),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .clear_done      (clear_done),
    .cmd_err         (cmd_err),
    .mem_op          (mem_op),
    .mem_select      (mem_select),
    .mem_address     (mem_address),
    .mem_data_input  (mem_data_input),
    .mem_data_output (mem_data_output)
  );

  // Behavioural 8x8 array: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_select && mem_op) arr[mem_address] <= mem_data_input;
  assign mem_data_output = arr[mem_address];

  always @(negedge clk) if (mem_select) sel_cycles++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (req_ready !== 1'b1) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b01; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
    check("wr_sel",   mem_select, 1);
    check("wr_op",    mem_op, 1);
    check("wr_addr",  mem_address, a);
    check("wr_data",  mem_data_input, d);
    check("wr_busy",  req_ready, 0);
    step();
    check("wr_end_sel", mem_select, 0);
    check("wr_ready",   req_ready, 1);
    ref_mem[a] = d;
    exp_sel++;
  endtask

  task automatic do_read(input logic [2:0] a, input int hold);
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b00; req_addr = a; req_wdata = 8'($urandom);
    step();
    req_valid = 1'b0;
    check("rd_sel",  mem_select, 1);
    check("rd_op",   mem_op, 0);
    check("rd_addr", mem_address, a);
    check("rd_early_valid", rsp_valid, 0);
    step();
    check("rd_valid", rsp_valid, 1);
    check("rd_data",  rsp_rdata, ref_mem[a]);
    check("rd_idle_sel", mem_select, 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("rd_hold_valid", rsp_valid, 1);
      check("rd_hold_data",  rsp_rdata, ref_mem[a]);
      check("rd_hold_busy",  req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rd_done_valid", rsp_valid, 0);
    check("rd_done_ready", req_ready, 1);
    exp_sel++;
  endtask

  task automatic do_clear();
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b10; req_addr = 3'($urandom); req_wdata = 8'($urandom);
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("clr_sel",  mem_select, 1);
      check("clr_op",   mem_op, 1);
      check("clr_addr", mem_address, k);
      check("clr_data", mem_data_input, 0);
      check("clr_early_done", clear_done, 0);
      check("clr_busy", req_ready, 0);
      step();
    end
    check("clr_done",  clear_done, 1);
    check("clr_ready", req_ready, 1);
    check("clr_end_sel", mem_select, 0);
    step();
    check("clr_done_pulse", clear_done, 0);
    for (int r = 0; r < 8; r++) ref_mem[r] = 8'h00;
    exp_sel += 8;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},  req_ready, 0);
    check({tag, "_rsp_valid"},  rsp_valid, 0);
    check({tag, "_rsp_rdata"},  rsp_rdata, 0);
    check({tag, "_clear_done"}, clear_done, 0);
    check({tag, "_cmd_err"},    cmd_err, 0);
    check({tag, "_mem"}, {mem_op, mem_select, mem_address, mem_data_input}, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++) begin
      arr[r] = 8'h00;
      ref_mem[r] = 8'h00;
    end
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_cmd = 2'b00; req_addr = '0; req_wdata = '0;
    #2 reset = 1'b1;
    step(); step();
    check_all_zero("in_reset");
    reset = 1'b0;
    step();
    check("rel_ready", req_ready, 1);
    check("rel_rsp_valid", rsp_valid, 0);
    check("rel_mem", {mem_op, mem_select, mem_address, mem_data_input}, 0);
    repeat (3) step();
    check("idle_no_sel", sel_cycles, 0);

    // Write 0xA5 to row 5 and read it back with no backpressure.
    do_write(3'd5, 8'hA5);
    do_read(3'd5, 0);

    // Backpressure with a request held pending until after the handshake.
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b00; req_addr = 3'd5;
    step();
    req_cmd = 2'b01; req_addr = 3'd2; req_wdata = 8'h3C;
    step();
    check("bp_valid", rsp_valid, 1);
    check("bp_data",  rsp_rdata, 8'hA5);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data",  rsp_rdata, 8'hA5);
      check("bp_hold_busy",  req_ready, 0);
      check("bp_no_accept",  mem_select, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_hs_valid", rsp_valid, 0);
    check("bp_hs_ready", req_ready, 1);
    check("bp_hs_sel",   mem_select, 0);
    step();
    req_valid = 1'b0;
    check("bp_pend_sel",  mem_select, 1);
    check("bp_pend_op",   mem_op, 1);
    check("bp_pend_addr", mem_address, 3'd2);
    check("bp_pend_data", mem_data_input, 8'h3C);
    step();
    ref_mem[2] = 8'h3C;
    exp_sel += 2;

    // Fill with 0xFF, clear, and read every row back.
    for (int r = 0; r < 8; r++) do_write(3'(r), 8'hFF);
    do_clear();
    for (int r = 0; r < 8; r++) do_read(3'(r), 0);

    // Reserved command, then an immediate back-to-back write.
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b11; req_addr = 3'd6; req_wdata = 8'h77;
    step();
    req_valid = 1'b0;
    check("rsvd_err",   cmd_err, 1);
    check("rsvd_ready", req_ready, 1);
    check("rsvd_sel",   mem_select, 0);
    check("rsvd_valid", rsp_valid, 0);
    do_write(3'd6, 8'h66);
    check("rsvd_err_pulse", cmd_err, 0);

    // Randomized traffic against the expected-contents model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:             do_clear();
        1, 2, 3, 4:    do_write(3'($urandom), 8'($urandom));
        default:       do_read(3'($urandom), int'($urandom_range(0, 3)));
      endcase
    end

    // Reset during the clear cycle that drives row 3.
    for (int r = 0; r < 8; r++) do_write(3'(r), 8'h10 + 8'(r) * 8'h11);
    do_read(3'd7, 1);
    wait_ready();
    req_valid = 1'b1; req_cmd = 2'b10;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    check("mid_clr_row3", mem_address, 3'd3);
    reset = 1'b1;
    #1;
    check_all_zero("mid_clr_reset");
    step();
    check("mid_clr_no_done", clear_done, 0);
    reset = 1'b0;
    step();
    check("mid_clr_rel_ready", req_ready, 1);
    check("mid_clr_rel_done",  clear_done, 0);
    for (int r = 0; r < 3; r++) ref_mem[r] = 8'h00;
    exp_sel += 3;
    for (int r = 0; r < 8; r++) do_read(3'(r), 0);

    step();
    check("sel_cycles", sel_cycles, exp_sel);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
